// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128/192/256 inverse cipher: sequential key expansion, then one inverse round per clock.
// Optional CBC chaining is enabled with the AES_DEC_CBC_EN macro.
module aes_decrypt_iter #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6,
  parameter int Nb = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [Nk*32-1:0]  key_in,
  input  logic              key_load,
  output logic              key_ready,
  input  logic [127:0]      data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [127:0]      data_out,
  output logic              out_valid,
  input  logic              out_ready
`ifdef AES_DEC_CBC_EN
  ,
  input  logic [127:0]      iv_in,
  input  logic              iv_load
`endif
);

  if (!(Nk == 4 || Nk == 6 || Nk == 8) || Nr != Nk + 6 || Nb != 4) begin : g_bad_cfg
    $fatal(1, "aes_decrypt_iter: Nk must be 4, 6 or 8 with Nr = Nk + 6 and Nb = 4");
  end

  localparam int NW = Nb * (Nr + 1);
  localparam int IW = $clog2(NW);
  localparam int RW = $clog2(Nr + 1);

  typedef enum logic [2:0] {IDLE, KEXP, READY, ROUND, DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] res, p;
    res = 8'h01;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) res = gf_mul(res, p);
      p = gf_mul(p, p);
    end
    return res;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        o[127-8*(rr+4*c) -: 8] = s[127-8*(rr+4*((c-rr+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  state_t         state_q, state_d;
  logic [31:0]    w [NW];
  logic [IW-1:0]  widx;
  logic [2:0]     kmod;
  logic [7:0]     rcon;
  logic [RW-1:0]  r;
  logic [127:0]   st;
  logic [31:0]    temp, w_new;
  logic [RW-1:0]  r_sel;
  logic [IW-1:0]  rbase;
  logic [127:0]   rk_cur, last_out, mixed, plain;
  logic           key_acc, in_acc, out_hs, kexp_last, final_round;

  assign key_acc     = key_load && (state_q inside {IDLE, KEXP, READY});
  assign in_acc      = in_valid && in_ready;
  assign out_hs      = out_valid && out_ready;
  assign kexp_last   = (state_q == KEXP) && (widx == IW'(NW - 1));
  assign final_round = (state_q == ROUND) && (r == '0);

  // NOTE: every variable assigned in always_comb gets a value before any branch, so no latch is inferred.
  always_comb begin
    temp = w[widx - IW'(1)];
    if (kmod == 3'd0)
      temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h000000};
    else if (Nk == 8 && kmod == 3'd4)
      temp = sub_word(temp);
    w_new = w[widx - IW'(Nk)] ^ temp;
  end

  // Round key rk[Nr] whitens an incoming block; during ROUND the key follows the counter.
  assign r_sel    = (state_q == ROUND) ? r : RW'(Nr);
  assign rbase    = IW'({r_sel, 2'b00});
  assign rk_cur   = {w[rbase], w[rbase + IW'(1)], w[rbase + IW'(2)], w[rbase + IW'(3)]};
  assign last_out = inv_sub_bytes(inv_shift_rows(st)) ^ rk_cur;
  assign mixed    = inv_mix_columns(last_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (key_acc) state_d = KEXP;
      KEXP:    if (!key_acc && kexp_last) state_d = READY;
      READY:   if (key_acc) state_d = KEXP;
               else if (in_acc) state_d = ROUND;
      ROUND:   if (r == '0) state_d = DONE;
      DONE:    if (out_hs) state_d = in_acc ? ROUND : READY;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = !key_load && (state_q == READY || (state_q == DONE && out_ready));
`ifdef AES_DEC_CBC_EN
    if (iv_load && state_q == READY) in_ready = 1'b0;
`endif
  end

  // NOTE: the round-key file has no reset; it is only read once key_ready has been earned by an expansion.
  always_ff @(posedge clk) begin
    if (key_acc) begin
      for (int i = 0; i < Nk; i++) w[i] <= key_in[Nk*32-1-32*i -: 32];
    end else if (state_q == KEXP) begin
      w[widx] <= w_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      widx      <= IW'(Nk);
      kmod      <= 3'd0;
      rcon      <= 8'h01;
      key_ready <= 1'b0;
      r         <= '0;
      st        <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (key_acc) begin
        widx      <= IW'(Nk);
        kmod      <= 3'd0;
        rcon      <= 8'h01;
        key_ready <= 1'b0;
      end else if (state_q == KEXP) begin
        widx <= widx + IW'(1);
        kmod <= (kmod == 3'(Nk - 1)) ? 3'd0 : kmod + 3'd1;
        if (kmod == 3'd0) rcon <= xtime(rcon);
        if (kexp_last) key_ready <= 1'b1;
      end

      if (in_acc) begin
        st <= data_in ^ rk_cur;
        r  <= RW'(Nr - 1);
      end else if (state_q == ROUND && r != '0) begin
        st <= mixed;
        r  <= r - RW'(1);
      end

      if (final_round) begin
        data_out  <= plain;
        out_valid <= 1'b1;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef AES_DEC_CBC_EN
  logic [127:0] chain, pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain   <= '0;
      pending <= '0;
    end else begin
      if (iv_load && (state_q inside {IDLE, KEXP, READY})) chain <= iv_in;
      else if (final_round) chain <= pending;
      if (in_acc) pending <= data_in;
    end
  end

  assign plain = last_out ^ chain;
`else
  assign plain = last_out;
`endif

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Self-checking bench for aes_decrypt_iter: vector table through a scoreboard, plus handshake corner cases.
module tb_aes_decrypt_iter;
  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in, data_in, data_out;
  logic         key_load, key_ready, in_valid, in_ready, out_valid, out_ready;
`ifdef AES_DEC_CBC_EN
  logic [127:0] iv_in;
  logic         iv_load;
`endif

  logic [191:0] key6;
  logic [255:0] key8;
  logic [127:0] din6, din8, dout6, dout8;
  logic         kl_x, valid_x, kr6, kr8, ir6, ir8, ov6, ov8;

  always #5 clk = ~clk;

  aes_decrypt_iter dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load), .key_ready(key_ready),
    .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready)
`ifdef AES_DEC_CBC_EN
    , .iv_in(iv_in), .iv_load(iv_load)
`endif
  );

  aes_decrypt_iter #(.Nk(6)) dut6 (
    .clk(clk), .rst(rst), .key_in(key6), .key_load(kl_x), .key_ready(kr6),
    .data_in(din6), .in_valid(valid_x), .in_ready(ir6),
    .data_out(dout6), .out_valid(ov6), .out_ready(1'b1)
`ifdef AES_DEC_CBC_EN
    , .iv_in(128'h0), .iv_load(1'b0)
`endif
  );

  aes_decrypt_iter #(.Nk(8)) dut8 (
    .clk(clk), .rst(rst), .key_in(key8), .key_load(kl_x), .key_ready(kr8),
    .data_in(din8), .in_valid(valid_x), .in_ready(ir8),
    .data_out(dout8), .out_valid(ov8), .out_ready(1'b1)
`ifdef AES_DEC_CBC_EN
    , .iv_in(128'h0), .iv_load(1'b0)
`endif
  );

  typedef struct { logic [127:0] data; int cyc; } sb_t;
  typedef struct { logic [127:0] key; logic [127:0] ct; logic [127:0] pt; } vec_t;

  sb_t          sb[$];
  vec_t         vec [5];
  int           checks = 0, failures = 0;
  int           cyc = 0, out_cnt = 0, last_rise = 0, last_gap = 0;
  logic         prev_ov = 1'b0;
  logic [127:0] cur_exp, cur_key, chain_m;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected plaintext for a ciphertext whose raw inverse-cipher output is pt.
  function automatic logic [127:0] model(input logic [127:0] ct, input logic [127:0] pt);
`ifdef AES_DEC_CBC_EN
    logic [127:0] res;
    res     = pt ^ chain_m;
    chain_m = ct;
    return res;
`else
    return pt;
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampling between active edges.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        last_gap  = cyc - last_rise;
        last_rise = cyc;
        if (sb.size() != 0) check("latency", cyc - sb[0].cyc, NR);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_out", 1, 0);
        else check("data_out", data_out, sb.pop_front().data);
        out_cnt++;
      end
      if (in_valid && in_ready) sb.push_back('{data: cur_exp, cyc: cyc + 1});
      prev_ov = out_valid;
    end
  end

  task automatic load_key(input logic [127:0] k);
    int n;
    key_in   = k;
    key_load = 1'b1;
    tick;
    key_load = 1'b0;
    check("key_ready_drop", key_ready, 0);
    n = 0;
    while (!key_ready && n < 200) begin tick; n++; end
    check("key_latency", n, 40);
    cur_key = k;
  endtask

  task automatic send(input logic [127:0] ct, input logic [127:0] exp);
    int n;
    data_in  = ct;
    cur_exp  = exp;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin tick; n++; end
    check("accept_timeout", n < 100, 1);
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int target);
    int n;
    n = 0;
    while (out_cnt < target && n < 100) begin tick; n++; end
    check("out_timeout", out_cnt >= target, 1);
  endtask

  initial begin
    int t, t6, t8, bad_stab, bad_ir, n;
    vec[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
               pt: 128'h00112233445566778899aabbccddeeff};
    vec[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, ct: 128'h3ad77bb40d7a3660a89ecaf32466ef97,
               pt: 128'h6bc1bee22e409f96e93d7e117393172a};
    vec[2] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, ct: 128'hf5d3d58503b9699de785895a96fdbaaf,
               pt: 128'hae2d8a571e03ac9c9eb76fac45af8e51};
    vec[3] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, ct: 128'h43b1cd7f598ece23881b00e3ed030688,
               pt: 128'h30c81c46a35ce411e5fbc1191a0a52ef};
    vec[4] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, ct: 128'h7b0c785e27e8ad3f8223207104725dd4,
               pt: 128'hf69f2445df4f9b17ad2b417be66c3710};

    rst = 1'b1; key_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    key_in = '0; data_in = '0; cur_exp = '0; cur_key = 'x; chain_m = '0;
    kl_x = 1'b0; valid_x = 1'b0; key6 = '0; key8 = '0; din6 = '0; din8 = '0;
`ifdef AES_DEC_CBC_EN
    iv_in = '0; iv_load = 1'b0;
`endif
    repeat (2) tick;
    check("rst_key_ready", key_ready, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 128'h0);
    rst = 1'b0;
    tick;
    in_valid = 1'b1;
    #1;
    check("idle_in_ready", in_ready, 0);
    in_valid = 1'b0;

    // Vector table through the scoreboard.
    for (int i = 0; i < 5; i++) begin
      if (vec[i].key !== cur_key || !key_ready) load_key(vec[i].key);
      t = out_cnt + 1;
      send(vec[i].ct, model(vec[i].ct, vec[i].pt));
      wait_out(t);
    end

    // Output stall for 20 cycles with a second block waiting.
    out_ready = 1'b0;
    t = out_cnt + 1;
    send(vec[1].ct, model(vec[1].ct, vec[1].pt));
    n = 0;
    while (!out_valid && n < 50) begin tick; n++; end
    check("stall_out_valid", out_valid, 1);
    data_in  = vec[2].ct;
    cur_exp  = model(vec[2].ct, vec[2].pt);
    in_valid = 1'b1;
    bad_stab = 0;
    bad_ir   = 0;
    repeat (20) begin
      tick;
      if (data_out !== sb[0].data || !out_valid) bad_stab++;
      if (in_ready) bad_ir++;
    end
    check("stall_stable", bad_stab, 0);
    check("stall_in_ready", bad_ir, 0);
    out_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1);
    tick;
    in_valid = 1'b0;
    wait_out(t + 1);

    // Back-to-back blocks.
    t = out_cnt + 2;
    send(vec[3].ct, model(vec[3].ct, vec[3].pt));
    send(vec[4].ct, model(vec[4].ct, vec[4].pt));
    wait_out(t);
    check("b2b_gap", last_gap, NR + 1);

    // key_load while ROUND is running is ignored.
    t = out_cnt + 1;
    send(vec[1].ct, model(vec[1].ct, vec[1].pt));
    repeat (3) tick;
    key_in   = vec[0].key;
    key_load = 1'b1;
    tick;
    key_load = 1'b0;
    key_in   = cur_key;
    check("kl_round_key_ready", key_ready, 1);
    wait_out(t);

    // key_load and in_valid together in READY: key wins, block follows re-expansion.
    data_in  = vec[0].ct;
    cur_exp  = model(vec[0].ct, vec[0].pt);
    in_valid = 1'b1;
    key_in   = vec[0].key;
    key_load = 1'b1;
    #1;
    check("sim_in_ready", in_ready, 0);
    tick;
    key_load = 1'b0;
    check("sim_key_ready_drop", key_ready, 0);
    n = 0;
    while (!in_ready && n < 200) begin tick; n++; end
    check("sim_reexp", n, 40);
    cur_key = vec[0].key;
    t = out_cnt + 1;
    tick;
    in_valid = 1'b0;
    wait_out(t);

    // Reset in the middle of a block.
    t = out_cnt;
    send(vec[0].ct, model(vec[0].ct, vec[0].pt));
    repeat (5) tick;
    rst = 1'b1;
    #1;
    check("mid_rst_key_ready", key_ready, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_data_out", data_out, 128'h0);
    tick;
    rst     = 1'b0;
    chain_m = '0;
    repeat (20) tick;
    check("mid_rst_no_out", out_cnt, t);
    check("mid_rst_out_valid_after", out_valid, 0);

`ifdef AES_DEC_CBC_EN
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    iv_in   = 128'h000102030405060708090a0b0c0d0e0f;
    iv_load = 1'b1;
    tick;
    iv_load = 1'b0;
    t = out_cnt + 2;
    send(128'h7649abac8119b246cee98e9b12e9197d, 128'h6bc1bee22e409f96e93d7e117393172a);
    send(128'h5086cb9b507219ee95db113a917678b2, 128'hae2d8a571e03ac9c9eb76fac45af8e51);
    wait_out(t);
`endif

    // AES-192 and AES-256 instances.
    key6 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    key8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    kl_x = 1'b1;
    tick;
    kl_x = 1'b0;
    t6 = 0;
    t8 = 0;
    for (int k = 1; k <= 60; k++) begin
      tick;
      if (kr6 && t6 == 0) t6 = k;
      if (kr8 && t8 == 0) t8 = k;
    end
    check("k192_latency", t6, 46);
    check("k256_latency", t8, 52);
    din6    = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    din8    = 128'h8ea2b7ca516745bfeafc49904b496089;
    valid_x = 1'b1;
    #1;
    check("x_in_ready", ir6 && ir8, 1);
    tick;
    valid_x = 1'b0;
    t6 = 0;
    t8 = 0;
    for (int k = 1; k <= 20; k++) begin
      tick;
      if (ov6 && t6 == 0) t6 = k;
      if (ov8 && t8 == 0) t8 = k;
    end
    check("aes192_latency", t6, 12);
    check("aes256_latency", t8, 14);
    check("aes192_data", dout6, 128'h00112233445566778899aabbccddeeff);
    check("aes256_data", dout8, 128'h00112233445566778899aabbccddeeff);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_decrypt_iter.md
# aes_decrypt_iter

Iterative, parametrised AES inverse cipher covering AES-128/192/256 from one RTL body selected by `Nk`. It holds an internal key schedule computed sequentially on key load. It decrypts one 128-bit block by executing one inverse round per clock, with valid/ready handshakes on input and output. It is the area-reduced successor to the fully unrolled decrypt datapath and sits between the block-input buffer and the plaintext sink.

## Interface
- `Nk`, default 4: key length in 32-bit words. Legal values are 4, 6, 8; any other value is a fatal elaboration error.
- `Nr`, default `Nk+6`: round count. Derived; must not be overridden.
- `Nb`, default 4: state columns. Fixed at 4.
- `clk`  in  1: the single clock, rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `key_in`  in  `Nk*32`: cipher key. `key_in[Nk*32-1 -: 32]` is word w[0].
- `key_load`  in  1: one-cycle strobe; starts key expansion from `key_in`.
- `key_ready`  out  1: the key schedule is complete and valid.
- `data_in`  in  128: ciphertext block. Bits [127:120] are state byte 0, in FIPS-197 column-major order.
- `in_valid`  in  1 / `in_ready`  out  1: input handshake.
- `data_out`  out  128: plaintext block.
- `out_valid`  out  1 / `out_ready`  in  1: output handshake.
- `iv_in`  in  128 / `iv_load`  in  1: CBC initial vector. These ports exist only with `AES_DEC_CBC_EN`.

## Operation
The FSM has five states: IDLE, KEXP, READY, ROUND, DONE. Reset forces IDLE.

Key loading:
- `key_load` is honoured in IDLE, KEXP (restarts the expansion) and READY. It is ignored in ROUND and DONE.
- On acceptance: w[0..Nk-1] are loaded from `key_in`, the word index becomes `Nk`, and the FSM enters KEXP.

KEXP:
- Computes one word per cycle per FIPS-197 KeyExpansion: RotWord/SubWord/Rcon when `i mod Nk == 0`; SubWord only when `Nk==8` and `i mod 8 == 4`.
- Runs until w[4(Nr+1)-1] is written, i.e. 40, 46 or 52 cycles for Nk = 4, 6, 8.
- Then goes to READY and sets `key_ready`.

Handshakes:
- `in_ready = !key_load && (READY || (DONE && out_ready))`.
- Input is accepted when `in_valid && in_ready`. On acceptance: `state <= data_in ^ rk[Nr]`, `r <= Nr-1`, next state ROUND.

ROUND:
- While `r > 0`: `state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[r])`, then `r <= r-1`.
- When `r == 0`: `data_out <= InvSubBytes(InvShiftRows(state)) ^ rk[0]`, `out_valid <= 1`, next state DONE.

DONE:
- Holds `data_out` stable until `out_valid && out_ready`.
- On that edge the FSM goes to ROUND if a new input is accepted on the same edge, otherwise to READY.

Other rules:
- The round-key file is 4(Nr+1) × 32 registers and is not reset.
- `key_ready` stays high from KEXP completion until the next accepted `key_load` or `rst`. A `key_load` accepted in READY drops `key_ready` on the next edge.
- A reset asserted mid-expansion or mid-block aborts immediately. The in-flight block is discarded and is never output.

## Timing
Reset values:
- `key_ready` = 0, `in_ready` = 0, `out_valid` = 0.
- `data_out` = 128'h0, round counter = 0, CBC chain register = 0.

Latency:
- An input accepted at edge E0 produces `out_valid` high after edge E0+Nr: 10, 12 or 14 cycles.

Throughput:
- One block per Nr+1 cycles with `out_ready` tied high, because an output handshake and an input acceptance can occur on the same edge.

Stall and ordering rules:
- Output stall: `data_out` and `out_valid` hold indefinitely; no input is accepted while stalled.
- Key expansion after an accepted `key_load` at edge K: `key_ready` rises after edge K + 4(Nr+1) − Nk.
- When `key_load` and `in_valid` are both high in READY, the key load wins (`in_ready` is forced low).

## Configuration
`AES_DEC_CBC_EN` controls CBC chaining.

Defined:
- `iv_in` and `iv_load` exist; `iv_load` is honoured in IDLE, KEXP and READY and sets `chain <= iv_in`.
- Each accepted ciphertext is captured into a pending register.
- On the final round: `data_out <= result ^ chain`, and `chain <= pending`.
- If `iv_load` and `in_valid` are both high in READY, the IV is loaded first and `in_ready` is low that cycle.

Undefined:
- ECB only. The chain and pending registers and the IV ports are absent, and `data_out` is the raw inverse-cipher output.

## Test plan
- **AES-128 (Nk=4):** key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a → pt 00112233445566778899aabbccddeeff. `key_ready` rises 40 cycles after `key_load`; `out_valid` rises 10 cycles after acceptance.
- **AES-192 and AES-256:** key 00..17, ct dda97ca4864cdfe06eaf70a0ec0d7191, and key 00..1f, ct 8ea2b7ca516745bfeafc49904b496089 → same pt. Latencies are 12 and 14 cycles.
- **Back-pressure:** `out_ready` low for 20 cycles → `data_out` stable and `in_ready` low throughout. Two back-to-back blocks with `out_ready` high → one output every 11 cycles (Nk=4).
- **Mid-operation events:** `rst` pulsed at round 5 → all outputs at reset values and no output is produced. `key_load` during ROUND → ignored and the result is correct.
- **CBC (`AES_DEC_CBC_EN`):** key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102030405060708090a0b0c0d0e0f. Ct 7649abac8119b246cee98e9b12e9197d → 6bc1bee22e409f96e93d7e117393172a, then ct 5086cb9b507219ee95db113a917678b2 → ae2d8a571e03ac9c9eb76fac45af8e51.
- **Simultaneous requests:** `key_load` and `in_valid` high together in READY → `in_ready` 0, then re-expansion, then the block is accepted once `key_ready` returns.
